// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment codes are active low, bit order {dp,g,f,e,d,c,b,a}.
package sseg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_ON   = 2'd2
    } scan_state_t;

    localparam logic [7:0] SSEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF   = 8'hFF;

    // Entry [n] is the glyph for hex digit n; bit 7 is replaced by ~dp on use.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex_seg(input logic [3:0] nib, input logic dp);
        logic [7:0] code;
        code = HEX_SEG[nib];
        return {~dp, code[6:0]};
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Load/display bundle between the host logic and the scan controller.
// master drives contents and blanking; slave drives the display pins.
interface sseg_scan_ctrl_if;

    logic        load;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  en_in;
    logic        blank;
    logic        load_ack;
    logic [7:0]  an;
    logic [7:0]  sseg;

    modport master (
        output load,
        output data_in,
        output dp_in,
        output en_in,
        output blank,
        input  load_ack,
        input  an,
        input  sseg
    );

    modport slave (
        input  load,
        input  data_in,
        input  dp_in,
        input  en_in,
        input  blank,
        output load_ack,
        output an,
        output sseg
    );

endinterface

// File: rtl/sseg_hex_dec.sv
// Combinational hex-to-segment decoder with decimal-point override.
module sseg_hex_dec
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    // Table lookup; a lit dp pulls bit 7 low.
    always_comb begin
        seg = hex_seg(nibble, dp);
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Scan controller for an 8-digit common-anode display: one anode at a time,
// dark gap between digits, new contents committed only at frame boundaries.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int ON_CYC     = 100000,
    parameter int GAP_CYC    = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    sseg_scan_ctrl_if.slave bus
);

    localparam int MAX_CYC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

    scan_state_t      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       idx_r, idx_s;

    logic [31:0] shadow_data_r, pend_data_r;
    logic [7:0]  shadow_dp_r, pend_dp_r;
    logic [7:0]  shadow_en_r, pend_en_r;
    logic        pend_r, pend_s;

    logic commit_in_s, commit_pend_s, capture_s;
    logic load_ack_r;
    logic [7:0] an_r, an_s;
    logic [7:0] sseg_r, sseg_s;
    logic [3:0] nib_s;
    logic [7:0] dec_seg_s;

    // Next-state, counter, digit index and buffering decisions.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        idx_s         = idx_r;
        commit_in_s   = 1'b0;
        commit_pend_s = 1'b0;
        capture_s     = 1'b0;
        pend_s        = pend_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.load) begin
                    state_s     = ST_GAP;
                    cnt_s       = {CNT_W{1'b0}};
                    idx_s       = 3'd0;
                    commit_in_s = 1'b1;
                end else begin
                    cnt_s = {CNT_W{1'b0}};
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_s = ST_ON;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_ON: begin
                if (cnt_r == ON_LAST) begin
                    state_s = ST_GAP;
                    cnt_s   = {CNT_W{1'b0}};
                    if (idx_r == IDX_LAST) begin
                        // Frame boundary: a same-cycle load beats older pending contents.
                        idx_s = 3'd0;
                        if (bus.load) begin
                            commit_in_s = 1'b1;
                        end else if (pend_r) begin
                            commit_pend_s = 1'b1;
                        end else begin
                            commit_pend_s = 1'b0;
                        end
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                idx_s   = 3'd0;
            end
        endcase

        if ((state_r != ST_IDLE) && bus.load && !commit_in_s) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end

        if (commit_in_s || commit_pend_s) begin
            pend_s = 1'b0;
        end else if (capture_s) begin
            pend_s = 1'b1;
        end else begin
            pend_s = pend_r;
        end
    end

    // Scan state, counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
        end
    end

    // Pending and shadow (displayed) contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r        <= 1'b0;
            pend_data_r   <= 32'h0000_0000;
            pend_dp_r     <= 8'h00;
            pend_en_r     <= 8'h00;
            shadow_data_r <= 32'h0000_0000;
            shadow_dp_r   <= 8'h00;
            shadow_en_r   <= 8'h00;
        end else begin
            pend_r <= pend_s;
            if (capture_s) begin
                pend_data_r <= bus.data_in;
                pend_dp_r   <= bus.dp_in;
                pend_en_r   <= bus.en_in;
            end
            if (commit_in_s) begin
                shadow_data_r <= bus.data_in;
                shadow_dp_r   <= bus.dp_in;
                shadow_en_r   <= bus.en_in;
            end else if (commit_pend_s) begin
                shadow_data_r <= pend_data_r;
                shadow_dp_r   <= pend_dp_r;
                shadow_en_r   <= pend_en_r;
            end
        end
    end

    sseg_hex_dec u_dec (
        .nibble (nib_s),
        .dp     (shadow_dp_r[idx_r]),
        .seg    (dec_seg_s)
    );

    // Pin values for the current slot; disabled or blanked digits still use their slot time.
    always_comb begin
        nib_s  = shadow_data_r[{idx_r, 2'b00} +: 4];
        an_s   = AN_OFF;
        sseg_s = SSEG_OFF;
        if (state_r == ST_ON) begin
            sseg_s = dec_seg_s;
            if (shadow_en_r[idx_r] && !bus.blank) begin
                an_s = ~(8'h01 << idx_r);
            end else begin
                an_s = AN_OFF;
            end
        end else begin
            an_s   = AN_OFF;
            sseg_s = SSEG_OFF;
        end
    end

    // Registered display pins and commit acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r       <= AN_OFF;
            sseg_r     <= SSEG_OFF;
            load_ack_r <= 1'b0;
        end else begin
            an_r       <= an_s;
            sseg_r     <= sseg_s;
            load_ack_r <= commit_in_s | commit_pend_s;
        end
    end

    assign bus.an       = an_r;
    assign bus.sseg     = sseg_r;
    assign bus.load_ack = load_ack_r;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench: randomized and directed scenarios against a timing model
// that locates each cycle within slot/frame by arithmetic on a running cycle count.
module tb_sseg_scan_ctrl;

    localparam int ND    = 8;
    localparam int ONC   = 4;
    localparam int GAPC  = 1;
    localparam int SLOT  = ONC + GAPC;
    localparam int FRAME = SLOT * ND;

    localparam logic [7:0] SEG_REF [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    sseg_scan_ctrl_if bus ();

    sseg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .ON_CYC     (ONC),
        .GAP_CYC    (GAPC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    bit          m_run;
    int          m_pos;
    logic [31:0] m_sd, m_pd;
    logic [7:0]  m_sdp, m_sen, m_pdp, m_pen;
    bit          m_pf;
    logic [7:0]  exp_an, exp_sseg;
    logic        exp_ack;

    task automatic model_reset();
        m_run = 1'b0; m_pos = 0; m_pf = 1'b0;
        m_sd = 32'h0; m_sdp = 8'h00; m_sen = 8'h00;
        m_pd = 32'h0; m_pdp = 8'h00; m_pen = 8'h00;
        exp_an = 8'hFF; exp_sseg = 8'hFF; exp_ack = 1'b0;
    endtask

    task automatic drive(input logic ld, input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
        bus.load = ld; bus.data_in = d; bus.dp_in = dp; bus.en_in = en;
    endtask

    // One clock: predict outputs from pre-edge state, advance model, settle.
    task automatic tick();
        int d;
        logic [7:0] one;
        logic [3:0] nib;
        one = 8'h01;
        exp_an = 8'hFF;
        exp_sseg = 8'hFF;
        if (m_run && (m_pos % SLOT) >= GAPC) begin
            d = (m_pos / SLOT) % ND;
            nib = m_sd[4*d +: 4];
            exp_sseg = {~m_sdp[d], SEG_REF[nib][6:0]};
            if (m_sen[d] && !bus.blank) exp_an = ~(one << d);
        end
        @(posedge clk);
        exp_ack = 1'b0;
        if (!m_run) begin
            if (bus.load) begin
                m_run = 1'b1; m_pos = 0; m_pf = 1'b0;
                m_sd = bus.data_in; m_sdp = bus.dp_in; m_sen = bus.en_in;
                exp_ack = 1'b1;
            end
        end else begin
            m_pos++;
            if (m_pos % FRAME == 0) begin
                if (bus.load) begin
                    m_sd = bus.data_in; m_sdp = bus.dp_in; m_sen = bus.en_in;
                    m_pf = 1'b0; exp_ack = 1'b1;
                end else if (m_pf) begin
                    m_sd = m_pd; m_sdp = m_pdp; m_sen = m_pen;
                    m_pf = 1'b0; exp_ack = 1'b1;
                end
            end else if (bus.load) begin
                m_pd = bus.data_in; m_pdp = bus.dp_in; m_pen = bus.en_in; m_pf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 8'h00, 8'h00);
        bus.blank = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.an, bus.sseg, bus.load_ack} !== {8'hFF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_state an/sseg/ack=%h/%h/%b want ff/ff/0", bus.an, bus.sseg, bus.load_ack);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 50; i++) begin
            tick();
            vectors++;
            if ({bus.an, bus.sseg, bus.load_ack} !== {8'hFF, 8'hFF, 1'b0}) begin
                errors++;
                $display("FAIL idle_dark cyc=%0d an/sseg/ack=%h/%h/%b want ff/ff/0", i, bus.an, bus.sseg, bus.load_ack);
            end
        end
    endtask

    task automatic test_basic_scan();
        drive(1'b1, 32'h0123ABCD, 8'h00, 8'hFF);
        tick();
        drive(1'b0, 32'h0, 8'h00, 8'h00);
        vectors++;
        if (bus.load_ack !== 1'b1) begin
            errors++;
            $display("FAIL first_ack got %b want 1", bus.load_ack);
        end
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            tick();
            vectors++;
            if ({bus.an, bus.sseg, bus.load_ack} !== {exp_an, exp_sseg, exp_ack}) begin
                errors++;
                $display("FAIL basic_scan cyc=%0d an/sseg/ack=%h/%h/%b want %h/%h/%b",
                         i, bus.an, bus.sseg, bus.load_ack, exp_an, exp_sseg, exp_ack);
            end
            if (i == 1 || i == 36) begin
                vectors++;
                if ({bus.an, bus.sseg} !== ((i == 1) ? {8'hFE, 8'hA1} : {8'h7F, 8'hC0})) begin
                    errors++;
                    $display("FAIL basic_digit cyc=%0d an/sseg=%h/%h", i, bus.an, bus.sseg);
                end
            end
        end
    endtask

    task automatic test_midframe_load();
        int n = 0;
        int acks = 0;
        bit ack_seen = 1'b0;
        while (exp_an !== 8'hF7 && n < 2 * FRAME) begin
            tick(); n++;
        end
        vectors++;
        if (n >= 2 * FRAME) begin errors++; $display("FAIL midframe_wait timeout got %0d want <%0d", n, 2 * FRAME); end
        drive(1'b1, 32'hFFFFFFFF, 8'h00, 8'hFF);
        for (int i = 0; i < FRAME + 10; i++) begin
            tick();
            drive(1'b0, 32'h0, 8'h00, 8'h00);
            vectors++;
            if ({bus.an, bus.sseg, bus.load_ack} !== {exp_an, exp_sseg, exp_ack}) begin
                errors++;
                $display("FAIL midframe cyc=%0d an/sseg/ack=%h/%h/%b want %h/%h/%b",
                         i, bus.an, bus.sseg, bus.load_ack, exp_an, exp_sseg, exp_ack);
            end
            if (ack_seen && bus.an === 8'hFE) begin
                vectors++;
                if (bus.sseg !== 8'h8E) begin errors++; $display("FAIL midframe_new_digit0 got %h want 8e", bus.sseg); end
            end
            if (bus.load_ack === 1'b1) begin acks++; ack_seen = 1'b1; end
        end
        vectors++;
        if (acks != 1) begin errors++; $display("FAIL midframe_ack_count got %0d want 1", acks); end
    endtask

    task automatic test_double_load();
        int n = 0;
        int acks = 0;
        bit ack_seen = 1'b0;
        while (exp_an !== 8'hFE && n < 2 * FRAME) begin
            tick(); n++;
        end
        vectors++;
        if (n >= 2 * FRAME) begin errors++; $display("FAIL double_wait timeout got %0d want <%0d", n, 2 * FRAME); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 0) drive(1'b1, 32'h11111111, 8'h00, 8'hFF);
            else if (i == 4) drive(1'b1, 32'h22222222, 8'h00, 8'hFF);
            else drive(1'b0, 32'h0, 8'h00, 8'h00);
            tick();
            vectors++;
            if ({bus.an, bus.sseg, bus.load_ack} !== {exp_an, exp_sseg, exp_ack}) begin
                errors++;
                $display("FAIL double_load cyc=%0d an/sseg/ack=%h/%h/%b want %h/%h/%b",
                         i, bus.an, bus.sseg, bus.load_ack, exp_an, exp_sseg, exp_ack);
            end
            if (ack_seen && bus.an !== 8'hFF) begin
                vectors++;
                if (bus.sseg !== 8'hA4) begin errors++; $display("FAIL double_last_wins got %h want a4", bus.sseg); end
            end
            if (bus.load_ack === 1'b1) begin acks++; ack_seen = 1'b1; end
        end
        drive(1'b0, 32'h0, 8'h00, 8'h00);
        vectors++;
        if (acks != 1) begin errors++; $display("FAIL double_ack_count got %0d want 1", acks); end
    endtask

    task automatic test_en_dp_blank();
        int n = 0;
        drive(1'b1, 32'h00000000, 8'h01, 8'h0F);
        tick();
        drive(1'b0, 32'h0, 8'h00, 8'h00);
        while (bus.load_ack !== 1'b1 && n < 2 * FRAME) begin
            tick(); n++;
        end
        vectors++;
        if (n >= 2 * FRAME) begin errors++; $display("FAIL en_ack_wait timeout got %0d want <%0d", n, 2 * FRAME); end
        for (int i = 0; i < 3 * FRAME; i++) begin
            bus.blank = (i >= FRAME) ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            vectors++;
            if ({bus.an, bus.sseg, bus.load_ack} !== {exp_an, exp_sseg, exp_ack}) begin
                errors++;
                $display("FAIL en_dp_blank cyc=%0d an/sseg/ack=%h/%h/%b want %h/%h/%b",
                         i, bus.an, bus.sseg, bus.load_ack, exp_an, exp_sseg, exp_ack);
            end
            if (i < FRAME && bus.an === 8'hFE) begin
                vectors++;
                if (bus.sseg !== 8'h40) begin errors++; $display("FAIL dp_digit0 got %h want 40", bus.sseg); end
            end
        end
        bus.blank = 1'b0;
        n = 0;
        while (exp_an !== 8'hFE && n < 2 * FRAME) begin
            tick(); n++;
        end
        bus.blank = 1'b1;
        tick();
        vectors++;
        if (bus.an !== 8'hFF) begin errors++; $display("FAIL blank_forces_off got %h want ff", bus.an); end
        bus.blank = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            vectors++;
            if ({bus.an, bus.sseg} !== {exp_an, exp_sseg}) begin
                errors++;
                $display("FAIL blank_release cyc=%0d an/sseg=%h/%h want %h/%h", i, bus.an, bus.sseg, exp_an, exp_sseg);
            end
        end
    endtask

    task automatic test_boundary_load();
        int n = 0;
        int acks = 0;
        bit ack_seen = 1'b0;
        while (exp_an !== 8'hFD && n < 2 * FRAME) begin
            tick(); n++;
        end
        drive(1'b1, 32'h33333333, 8'h00, 8'hFF);
        tick();
        drive(1'b0, 32'h0, 8'h00, 8'h00);
        n = 0;
        while (((m_pos + 1) % FRAME) != 0 && n < 2 * FRAME) begin
            tick(); n++;
        end
        vectors++;
        if (n >= 2 * FRAME) begin errors++; $display("FAIL boundary_wait timeout got %0d want <%0d", n, 2 * FRAME); end
        drive(1'b1, 32'h89ABCDE5, 8'h00, 8'hFF);
        for (int i = 0; i < FRAME + 5; i++) begin
            tick();
            drive(1'b0, 32'h0, 8'h00, 8'h00);
            vectors++;
            if ({bus.an, bus.sseg, bus.load_ack} !== {exp_an, exp_sseg, exp_ack}) begin
                errors++;
                $display("FAIL boundary_load cyc=%0d an/sseg/ack=%h/%h/%b want %h/%h/%b",
                         i, bus.an, bus.sseg, bus.load_ack, exp_an, exp_sseg, exp_ack);
            end
            if (ack_seen && bus.an === 8'hFE) begin
                vectors++;
                if (bus.sseg !== 8'h92) begin errors++; $display("FAIL boundary_load_wins got %h want 92", bus.sseg); end
            end
            if (bus.load_ack === 1'b1) begin acks++; ack_seen = 1'b1; end
        end
        vectors++;
        if (acks != 1) begin errors++; $display("FAIL boundary_ack_count got %0d want 1", acks); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) == 0), $urandom, 8'($urandom), 8'($urandom));
            bus.blank = ($urandom_range(0, 7) == 0);
            tick();
            vectors++;
            if ({bus.an, bus.sseg, bus.load_ack} !== {exp_an, exp_sseg, exp_ack}) begin
                errors++;
                $display("FAIL random cyc=%0d an/sseg/ack=%h/%h/%b want %h/%h/%b",
                         i, bus.an, bus.sseg, bus.load_ack, exp_an, exp_sseg, exp_ack);
            end
        end
        drive(1'b0, 32'h0, 8'h00, 8'h00);
        bus.blank = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        drive(1'b1, 32'h55555555, 8'h00, 8'hFF);
        tick();
        drive(1'b0, 32'h0, 8'h00, 8'h00);
        while (!(m_sd == 32'h55555555 && m_sen == 8'hFF && !m_pf) && n < 3 * FRAME) begin
            tick(); n++;
        end
        n = 0;
        while (exp_an !== 8'hDF && n < 2 * FRAME) begin
            tick(); n++;
        end
        vectors++;
        if (bus.an !== 8'hDF || n >= 2 * FRAME) begin
            errors++;
            $display("FAIL reset_mid_pre an=%h want df (waited %0d)", bus.an, n);
        end
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({bus.an, bus.sseg, bus.load_ack} !== {8'hFF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_async an/sseg/ack=%h/%h/%b want ff/ff/0", bus.an, bus.sseg, bus.load_ack);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 25; i++) begin
            if (i == 20) drive(1'b1, 32'h00000007, 8'h00, 8'h01);
            else drive(1'b0, 32'h0, 8'h00, 8'h00);
            tick();
            vectors++;
            if ({bus.an, bus.sseg, bus.load_ack} !== {exp_an, exp_sseg, exp_ack}) begin
                errors++;
                $display("FAIL reset_mid_after cyc=%0d an/sseg/ack=%h/%h/%b want %h/%h/%b",
                         i, bus.an, bus.sseg, bus.load_ack, exp_an, exp_sseg, exp_ack);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_scan();
        test_midframe_load();
        test_double_load();
        test_en_dp_blank();
        test_boundary_load();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
